// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared constants and types for the RV32I instruction encoder/loader:
//   - opcode, funct3 and funct7 field values
//   - op_type / alu_sel request encodings
//   - loader state-machine state type
// No ports (package).
// -----------------------------------------------------------------------------
package instr_enc_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam logic [6:0] F7_BASE    = 7'b0000000;

    typedef enum logic [1:0] {
        OP_R      = 2'b00,
        OP_LOAD   = 2'b01,
        OP_STORE  = 2'b10,
        OP_BRANCH = 2'b11
    } op_type_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/instr_enc_comb.sv
// -----------------------------------------------------------------------------
// instr_enc_comb
// Purely combinational field-to-word RV32I encoder (R, I-load, S, B formats).
// Fields a format does not use are not encoded; imm[0] never reaches a branch.
// Ports:
//   i_op_type [1:0]  instruction class
//   i_alu_sel [1:0]  R-type operation
//   i_rd, i_rs1, i_rs2 [4:0] register indices
//   i_imm [12:0]     signed immediate
//   o_instr [31:0]   encoded instruction word
// -----------------------------------------------------------------------------
module instr_enc_comb
    import instr_enc_pkg::*;
(
    input  logic [1:0]  i_op_type,
    input  logic [1:0]  i_alu_sel,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [12:0] i_imm,
    output logic [31:0] o_instr
);

    logic [2:0] w_r_f3;
    logic [6:0] w_r_f7;

    always_comb begin
        w_r_f3 = F3_ADD_SUB;
        case (i_alu_sel)
            ALU_AND: w_r_f3 = F3_AND;
            ALU_OR:  w_r_f3 = F3_OR;
            default: w_r_f3 = F3_ADD_SUB;
        endcase
        w_r_f7 = (i_alu_sel == ALU_SUB) ? F7_SUB : F7_BASE;
    end

    always_comb begin
        o_instr = '0;
        case (i_op_type)
            OP_R:      o_instr = {w_r_f7, i_rs2, i_rs1, w_r_f3, i_rd, OPC_RTYPE};
            OP_LOAD:   o_instr = {i_imm[11:0], i_rs1, F3_LW, i_rd, OPC_LOAD};
            OP_STORE:  o_instr = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OPC_STORE};
            OP_BRANCH: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                                  i_imm[4:1], i_imm[11], OPC_BRANCH};
            default:   o_instr = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts instruction-field requests over a valid/ready handshake, encodes them
// to RV32I words and writes them into instruction memory, one word per cycle,
// starting at address 0 for each session.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for the first start
// LOAD    | accepting requests, writing one word per accepted request
// DONE    | session finished (in_last seen or memory full), awaiting start
//
// Build option: IENC_ERR_CHECK_EN adds o_err and rejects illegal immediates.
// Ports:
//   i_clk, i_rst (sync, active-high)
//   i_start                session start pulse
//   i_in_valid/o_in_ready  request handshake, i_in_last marks final request
//   i_op_type, i_alu_sel, i_rd, i_rs1, i_rs2, i_imm  request fields
//   o_imem_we/o_imem_addr/o_imem_wdata  memory write port
//   o_count  words written this session, o_done  session complete
//   o_err    sticky illegal-request flag (IENC_ERR_CHECK_EN only)
// -----------------------------------------------------------------------------
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_last,
    input  logic [1:0]        i_op_type,
    input  logic [1:0]        i_alu_sel,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [12:0]       i_imm,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic [ADDR_W:0]   o_count,
`ifdef IENC_ERR_CHECK_EN
    output logic              o_err,
`endif
    output logic              o_done
);

    localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] C_PTR_MAX  = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       w_enc;
    logic              w_ready;
    logic              w_accept;
    logic              w_illegal;
    logic              w_write;
    logic              w_restart;

    instr_enc_comb u_enc (
        .i_op_type (i_op_type),
        .i_alu_sel (i_alu_sel),
        .i_rd      (i_rd),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_imm     (i_imm),
        .o_instr   (w_enc)
    );

`ifdef IENC_ERR_CHECK_EN
    logic r_err;
    assign w_illegal = ((i_op_type == OP_BRANCH) && i_imm[0]) ||
                       (((i_op_type == OP_LOAD) || (i_op_type == OP_STORE)) &&
                        (i_imm[12] != i_imm[11]));
    assign o_err     = r_err;
`else
    assign w_illegal = 1'b0;
`endif

    assign w_accept  = i_in_valid && w_ready;
    assign w_write   = w_accept && !w_illegal;
    // start is only honoured outside LOAD; it also rewinds pointer and count
    assign w_restart = i_start && (r_state != ST_LOAD);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_LOAD;
            ST_LOAD: begin
                // full when this write is the DEPTH-th one
                if (w_accept && (i_in_last || (w_write && r_count == C_LAST_CNT)))
                    w_next = ST_DONE;
            end
            ST_DONE: if (i_start) w_next = ST_LOAD;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == ST_LOAD) && (r_count < C_DEPTH);
        o_done  = (r_state == ST_DONE);
    end

    assign o_in_ready = w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_addr  <= r_ptr;
                r_wdata <= w_enc;
            end
            if (w_restart) begin
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_write) begin
                r_count <= r_count + 1'b1;
                if (r_ptr != C_PTR_MAX) r_ptr <= r_ptr + 1'b1;
            end
        end
    end

`ifdef IENC_ERR_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)                       r_err <= 1'b0;
        else if (w_restart)              r_err <= 1'b0;
        else if (w_accept && w_illegal)  r_err <= 1'b1;
    end
`endif

    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_count      = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed table of known encodings, hand sequences for session boundaries,
// fill-to-DEPTH and reset, then randomized traffic against a reference model.
// Build option: IENC_ERR_CHECK_EN (err port and illegal-request checks).
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic [1:0]        op_type = '0;
    logic [1:0]        alu_sel = '0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [12:0]       imm = '0;
    logic              o_in_ready;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic [ADDR_W:0]   o_count;
    logic              o_done;
`ifdef IENC_ERR_CHECK_EN
    logic              o_err;
`endif

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_in_valid   (in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_last    (in_last),
        .i_op_type    (op_type),
        .i_alu_sel    (alu_sel),
        .i_rd         (rd),
        .i_rs1        (rs1),
        .i_rs2        (rs2),
        .i_imm        (imm),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_count      (o_count),
`ifdef IENC_ERR_CHECK_EN
        .o_err        (o_err),
`endif
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;

    // reference model state
    bit m_load = 0, m_done = 0, m_err = 0;
    int m_count = 0, m_ptr = 0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  alu;
        logic [4:0]  rd, rs1, rs2;
        logic [12:0] imm;
        bit          last;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] bits(input int unsigned v, input int lo, input int n);
        return (v >> lo) & ((32'd1 << n) - 1);
    endfunction

    // RV32I encoding from the field-placement rules
    function automatic logic [31:0] ref_enc(input logic [1:0] op, input logic [1:0] alu,
                                            input logic [4:0] d, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [12:0] im);
        int unsigned u = im;
        bit [31:0] regs = (32'(s2) << 20) | (32'(s1) << 15);
        bit [31:0] f3, f7;
        case (op)
            2'd0: begin
                f7 = (alu == 2'd1) ? 32'h20 : 32'h0;
                f3 = (alu == 2'd2) ? 32'd7 : (alu == 2'd3) ? 32'd6 : 32'd0;
                return (f7 << 25) | regs | (f3 << 12) | (32'(d) << 7) | 32'h33;
            end
            2'd1: return (bits(u, 0, 12) << 20) | (32'(s1) << 15) | (32'd2 << 12)
                         | (32'(d) << 7) | 32'h03;
            2'd2: return (bits(u, 5, 7) << 25) | regs | (32'd2 << 12)
                         | (bits(u, 0, 5) << 7) | 32'h23;
            default: return (bits(u, 12, 1) << 31) | (bits(u, 5, 6) << 25) | regs
                            | (bits(u, 1, 4) << 8) | (bits(u, 11, 1) << 7) | 32'h63;
        endcase
    endfunction

    function automatic bit ref_illegal(input logic [1:0] op, input logic [12:0] im);
`ifdef IENC_ERR_CHECK_EN
        if (op == 2'd3) return im[0];
        if (op == 2'd1 || op == 2'd2) return im[12] != im[11];
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: drive request, compare every output against the model
    task automatic cycle(input bit s, input bit v, input bit l,
                         input logic [1:0] op, input logic [1:0] alu,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [12:0] im, input bit use_exp, input logic [31:0] exp_word);
        bit exp_ready, acc, ill, wr;
        int exp_addr;
        logic [31:0] word;
        exp_ready = m_load && (m_count < DEPTH);
        chk("in_ready", 32'(o_in_ready), 32'(exp_ready));
        start = s; in_valid = v; in_last = l;
        op_type = op; alu_sel = alu; rd = d; rs1 = s1; rs2 = s2; imm = im;
        @(posedge clk); #1;
        acc = v && exp_ready;
        ill = acc && ref_illegal(op, im);
        wr  = acc && !ill;
        exp_addr = m_ptr;
        word = use_exp ? exp_word : ref_enc(op, alu, d, s1, s2, im);
        if (s && !m_load) begin
            m_load = 1; m_done = 0; m_count = 0; m_ptr = 0; m_err = 0;
        end else if (acc) begin
            if (wr) begin
                m_count++;
                if (m_ptr < DEPTH - 1) m_ptr++;
            end
            if (ill) m_err = 1;
            if (l || (wr && m_count == DEPTH)) begin
                m_load = 0; m_done = 1;
            end
        end
        if (o_imem_we) wr_cnt++;
        chk("imem_we", 32'(o_imem_we), 32'(wr));
        if (wr) begin
            chk("imem_addr", 32'(o_imem_addr), 32'(exp_addr));
            chk("imem_wdata", o_imem_wdata, word);
        end
        chk("done", 32'(o_done), 32'(m_done));
        chk("count", 32'(o_count), 32'(m_count));
`ifdef IENC_ERR_CHECK_EN
        chk("err", 32'(o_err), 32'(m_err));
`endif
        start = 0; in_valid = 0; in_last = 0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'd0);
    endtask

    // reset while start and a valid request are also presented
    task automatic do_reset();
        rst = 1; start = 1; in_valid = 1;
        op_type = 2'd0; rd = 5'd7; rs1 = 5'd1; rs2 = 5'd2;
        @(posedge clk); #1;
        rst = 0; start = 0; in_valid = 0;
        m_load = 0; m_done = 0; m_err = 0; m_count = 0; m_ptr = 0;
        chk("rst_we", 32'(o_imem_we), 32'd0);
        chk("rst_addr", 32'(o_imem_addr), 32'd0);
        chk("rst_wdata", o_imem_wdata, 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_ready", 32'(o_in_ready), 32'd0);
`ifdef IENC_ERR_CHECK_EN
        chk("rst_err", 32'(o_err), 32'd0);
`endif
    endtask

    function automatic logic [12:0] legal_imm(input logic [1:0] op, input logic [12:0] im);
        logic [12:0] r = im;
        if (op == 2'd3) r[0] = 1'b0;
        if (op == 2'd1 || op == 2'd2) r[12] = r[11];
        return r;
    endfunction

    initial begin
        tbl[0] = '{2'd0, 2'd0, 5'd3,  5'd1, 5'd2, 13'h1ABC, 1'b0, 32'h002081B3};
        tbl[1] = '{2'd0, 2'd1, 5'd3,  5'd1, 5'd2, 13'h0000, 1'b0, 32'h402081B3};
        tbl[2] = '{2'd0, 2'd2, 5'd3,  5'd1, 5'd2, 13'h0000, 1'b0, 32'h0020F1B3};
        tbl[3] = '{2'd0, 2'd3, 5'd3,  5'd1, 5'd2, 13'h0000, 1'b0, 32'h0020E1B3};
        tbl[4] = '{2'd1, 2'd3, 5'd5,  5'd2, 5'd9, 13'h0008, 1'b0, 32'h00812283};
        tbl[5] = '{2'd2, 2'd1, 5'd31, 5'd2, 5'd6, 13'h000C, 1'b0, 32'h00612623};
        tbl[6] = '{2'd3, 2'd2, 5'd31, 5'd1, 5'd2, 13'h1FFC, 1'b1, 32'hFE208EE3};

        do_reset();
        // valid in IDLE is not accepted
        cycle(0, 1, 0, 2'd0, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1, 32'h002081B3);
        cycle(1, 0, 0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'd0);
        foreach (tbl[i])
            cycle(0, 1, tbl[i].last, tbl[i].op, tbl[i].alu, tbl[i].rd, tbl[i].rs1,
                  tbl[i].rs2, tbl[i].imm, 1, tbl[i].exp);
        // DONE: valid ignored, start rewinds to address 0
        cycle(0, 1, 0, 2'd0, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1, 32'h002081B3);
        cycle(1, 0, 0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'd0);
        cycle(0, 1, 0, 2'd0, 2'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1, 32'h002081B3);
        // start during LOAD is ignored, request still goes to addr 1
        cycle(1, 1, 0, 2'd1, 2'd0, 5'd5, 5'd2, 5'd0, 13'd8, 1, 32'h00812283);
`ifdef IENC_ERR_CHECK_EN
        cycle(0, 1, 0, 2'd3, 2'd0, 5'd0, 5'd1, 5'd2, 13'd3, 0, 32'd0);
        cycle(0, 1, 0, 2'd1, 2'd0, 5'd5, 5'd2, 5'd0, 13'h1800, 0, 32'd0);
        cycle(0, 1, 1, 2'd2, 2'd0, 5'd0, 5'd2, 5'd6, 13'h000C, 1, 32'h00612623);
        idle();
        cycle(1, 0, 0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'd0);
`else
        // branch imm[0] dropped silently
        cycle(0, 1, 1, 2'd3, 2'd0, 5'd31, 5'd1, 5'd2, 13'h1FFD, 1, 32'hFE208EE3);
        idle();
`endif

        // fill to DEPTH with valid held high
        do_reset();
        cycle(1, 0, 0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'd0);
        wr_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            cycle(0, 1, 0, op, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  legal_imm(op, 13'($urandom)), 0, 32'd0);
        end
        chk("fill_writes", 32'(wr_cnt), 32'd64);

        // reset the cycle after an acceptance, and reset on an accepting edge
        cycle(1, 0, 0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'd0);
        cycle(0, 1, 0, 2'd0, 2'd1, 5'd4, 5'd5, 5'd6, 13'd0, 0, 32'd0);
        do_reset();
        cycle(1, 0, 0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'd0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 16) == 0, ($urandom % 3) != 0, ($urandom % 30) == 0,
                  2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  13'($urandom), 0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameter DEPTH, default 64: instruction-memory words the loader may fill.
REQ-002 Parameter ADDR_W, default 6: imem address width, equal to log2(DEPTH).
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; begins a load session at word address 0.
REQ-006 in_valid  in  1  the request fields are valid.
REQ-007 in_ready  out  1  the block can accept a request this cycle.
REQ-008 in_last  in  1  qualifies the final request of the session.
REQ-009 op_type  in  2  instruction class: 00 R-type, 01 load (lw), 10 store (sw), 11 branch (beq).
REQ-010 alu_sel  in  2  R-type operation only: 00 add, 01 sub, 10 and, 11 or.
REQ-011 rd, rs1, rs2  in  5 each  register indices.
REQ-012 imm  in  13  signed immediate; load and store use bits [11:0]; branch uses bits [12:1].
REQ-013 imem_we  out  1  instruction-memory write strobe.
REQ-014 imem_addr  out  ADDR_W  word address of the write.
REQ-015 imem_wdata  out  32  encoded RV32I instruction.
REQ-016 count  out  ADDR_W+1  number of words written in the current session.
REQ-017 done  out  1  the session is complete.
REQ-018 err  out  1  sticky error flag; present only when the configuration macro is defined.

Function
REQ-019 The block SHALL implement a state machine with three states: IDLE, LOAD and DONE.
- IDLE -> LOAD on start.
- LOAD -> DONE on an accepted request with in_last, or on the DEPTH-th accepted write.
- DONE -> LOAD on start.
REQ-020 in_ready SHALL be 1 only in LOAD and only when count < DEPTH.
REQ-021 A request SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-022 Each accepted request SHALL produce exactly one write on the following cycle:
- imem_we is a one-cycle pulse;
- imem_wdata holds the encoding;
- imem_addr holds the write pointer before it increments.
REQ-023 Back-to-back acceptance SHALL sustain one write per cycle.
REQ-024 Encoding (opcode / funct3 / funct7):
- R-type: 0110011 / 000 for add and sub, 111 for and, 110 for or / 0100000 for sub, 0000000 otherwise.
- Load: 0000011 / 010.
- Store: 0100011 / 010.
- Branch: 1100011 / 000.
- Immediate bits are placed in the standard I, S or B field layout.
REQ-025 For a branch, imm[0] SHALL be ignored.
REQ-026 Fields that a format does not use SHALL be ignored, never encoded (for example rd on store and branch).
REQ-027 The write pointer and count SHALL increment per accepted request; the pointer stops at DEPTH-1, with no wrap-around.
REQ-028 start while in LOAD SHALL be ignored.
REQ-029 start while in DONE SHALL clear the pointer and count to 0 on the same edge.
REQ-030 done SHALL be 1 exactly while the state is DONE.
REQ-031 A request with in_valid high while in_ready is low SHALL be neither accepted nor written.

Reset
REQ-032 On rst the block SHALL enter IDLE and force the following to 0:
- in_ready, imem_we, imem_addr, imem_wdata;
- count, done, err.
REQ-033 rst asserted mid-session SHALL suppress any write pending for the next cycle.
REQ-034 rst SHALL take priority over start and in_valid in the same cycle.

Configuration
REQ-035 Macro IENC_ERR_CHECK_EN, when defined, SHALL add the err output and request checking.
- A request is illegal if it is a branch with imm[0]=1, or a load/store whose imm[12] differs from imm[11].
- An illegal request is accepted but not written, and count does not change.
- err is set on the edge after the illegal request and stays set until the next start or rst.
REQ-036 With IENC_ERR_CHECK_EN undefined:
- there is no err port;
- every accepted request is written;
- the ignored immediate bits are dropped silently.

Structure
REQ-037 Package instr_enc_pkg SHALL hold:
- the opcode, funct3 and funct7 constants;
- the op_type and alu_sel encodings;
- the state-machine state type.
REQ-038 Sub-module instr_enc_comb SHALL be the purely combinational field-to-word encoder, instantiated once.
REQ-039 The parent SHALL own the state machine, handshake, pointer, count and output registers.

Verification
REQ-040 start; R-type add rd=3 rs1=1 rs2=2 -> next cycle imem_we=1, addr 0, wdata 0x002081B3; the same fields with sub -> 0x402081B3.
REQ-041 Back-to-back requests lw x5,8(x2) then sw x6,12(x2) -> writes 0x00812283 at addr 0 and 0x00612623 at addr 1 on consecutive cycles.
REQ-042 beq x1,x2 with imm=-4 plus in_last -> wdata 0xFE208EE3, then done=1 and in_ready=0; start -> count=0, next write at addr 0.
REQ-043 With in_valid held high for 70 cycles -> exactly 64 writes at addresses 0..63, in_ready low thereafter, done=1.
REQ-044 rst on the cycle after an acceptance -> no imem_we, all outputs 0, state IDLE; with IENC_ERR_CHECK_EN defined, branch imm=3 -> no write, err=1 until the next start.
